// File: rtl/mem_burst_writer.sv
// Burst write sequencer for a 2^AW x DW sync-write / comb-read memory: writes a
// streamed burst at base..base+len-1 (mod 2^AW), then reads it back and compares XOR checksums.
module mem_burst_writer #(
    parameter int AW = 6,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_q,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [AW-1:0] base_r;
    logic [AW:0]   len_r;
    logic [AW:0]   cnt;
    logic [DW-1:0] wchk;
    logic [DW-1:0] rchk;
    logic          err_r;

    logic          len_legal;
    logic          last;
    logic [AW-1:0] addr_cur;

    assign len_legal = (len != '0) && (len <= MAX_LEN);
    assign last      = (cnt == (len_r - ONE));
    // Truncation to AW bits gives the modulo-2^AW wrap.
    assign addr_cur  = base_r + cnt[AW-1:0];
    assign err       = err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wchk  <= '0;
            rchk  <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_legal) begin
                            base_r <= base_addr;
                            len_r  <= len;
                            cnt    <= '0;
                            wchk   <= '0;
                            rchk   <= '0;
                            err_r  <= 1'b0;
                        end else begin
                            err_r  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (in_valid) begin
                        wchk <= wchk ^ in_data;
                        cnt  <= last ? '0 : cnt + ONE;
                    end
                end
                VERIFY: begin
                    rchk <= rchk ^ mem_q;
                    if (last) begin
                        cnt   <= '0;
                        // Fold in this cycle's read so the final checksum is compared.
                        err_r <= ((rchk ^ mem_q) != wchk);
                    end else begin
                        cnt   <= cnt + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = len_legal ? WRITE : DONE;
            end
            WRITE: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                mem_we   = in_valid;
                mem_addr = addr_cur;
                mem_din  = in_data;
                if (in_valid && last) state_nxt = VERIFY;
            end
            VERIFY: begin
                busy     = 1'b1;
                mem_addr = addr_cur;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_burst_writer.sv
// Testbench for mem_burst_writer: bench-owned 64x4 memory, randomized bursts with
// stalls, checked against expected addresses/contents/timing computed from the burst rules.
module tb_mem_burst_writer;
    localparam int AW = 6;
    localparam int DW = 4;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_q;
    logic          busy;
    logic          done;
    logic          err;

    mem_burst_writer #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_q(mem_q),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Memory: synchronous write, combinational read; flip corrupts q bit 0 during readback.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic          flip = 1'b0;
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
    assign mem_q = mem[mem_addr] ^ {{(DW-1){1'b0}}, flip & busy & ~in_ready};

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] beats[$];
    int            gaps[$];
    int            wr_addr[$];
    int            wr_data[$];
    int            vf_addr[$];
    bit            poke_start = 0;
    int            done_cyc;
    bit            err_seen;

    // Drives one burst (start, beats with idle gaps) and records what the DUT did.
    task automatic run_burst(input int b, input int l);
        int idx, gap_left, cyc;
        wr_addr.delete(); wr_data.delete(); vf_addr.delete();
        done_cyc = -1; err_seen = 0;
        @(posedge clk); #1;
        start = 1; base_addr = b[AW-1:0]; len = l[AW:0]; in_valid = 0;
        @(posedge clk); #1;
        start = 0; cyc = 1; idx = 0;
        gap_left = (gaps.size() > 0) ? gaps[0] : 0;
        forever begin
            if (poke_start && cyc == 2) begin
                start = 1; base_addr = ~b[AW-1:0]; len = 7'd3;
            end else begin
                start = 0;
            end
            in_valid = (idx < beats.size()) && (gap_left == 0);
            in_data  = in_valid ? beats[idx] : DW'($urandom);
            @(negedge clk);
            if (mem_we) begin wr_addr.push_back(int'(mem_addr)); wr_data.push_back(int'(mem_din)); end
            if (busy && !in_ready) vf_addr.push_back(int'(mem_addr));
            if (done) begin done_cyc = cyc; err_seen = err; break; end
            if (in_valid && in_ready) begin
                idx++;
                gap_left = (idx < gaps.size()) ? gaps[idx] : 0;
            end else if (in_ready && gap_left > 0) begin
                gap_left--;
            end
            if (cyc >= 400) begin
                $display("FAIL burst_timeout base=%0d len=%0d: no done within 400 cycles", b, l);
                rst = 1; @(posedge clk); #1; rst = 0;
                break;
            end
            @(posedge clk); #1; cyc++;
        end
        start = 0; in_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 1; base_addr = '0; len = 7'd4; in_valid = 1; in_data = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_din, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b we=%b addr=%0d din=%0d busy=%b done=%b err=%b want all 0",
                     in_ready, mem_we, mem_addr, mem_din, busy, done, err);
        end
        @(posedge clk); #1; rst = 0; start = 0; in_valid = 0;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_beats_start got busy=%b done=%b we=%b want 000", busy, done, mem_we);
        end
    endtask

    task automatic test_basic();
        int exp_d[4] = '{15, 10, 3, 5};
        beats = '{4'b1111, 4'b1010, 4'b0011, 4'b0101}; gaps.delete();
        run_burst(0, 4);
        checks++;
        if (done_cyc !== 9 || err_seen !== 1'b0) begin
            errors++; $display("FAIL basic_done got cyc=%0d err=%b want cyc=9 err=0", done_cyc, err_seen);
        end
        checks++;
        if (wr_addr.size() !== 4) begin
            errors++; $display("FAIL basic_we_cycles got %0d want 4", wr_addr.size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (int'(mem[k]) !== exp_d[k] || (k < wr_addr.size() && wr_addr[k] !== k)) begin
                errors++; $display("FAIL basic_mem[%0d] got %0d want %0d", k, mem[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_a[4] = '{62, 63, 0, 1};
        beats = '{4'd1, 4'd2, 4'd3, 4'd4}; gaps.delete();
        run_burst(62, 4);
        checks++;
        if (err_seen !== 1'b0 || done_cyc !== 9) begin
            errors++; $display("FAIL wrap_done got cyc=%0d err=%b want cyc=9 err=0", done_cyc, err_seen);
        end
        checks++;
        if (wr_addr.size() !== 4 || vf_addr.size() !== 4) begin
            errors++; $display("FAIL wrap_seq_len got wr=%0d vf=%0d want 4/4", wr_addr.size(), vf_addr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wr_addr[k] !== exp_a[k] || vf_addr[k] !== exp_a[k] || int'(mem[exp_a[k]]) !== k + 1) begin
                    errors++;
                    $display("FAIL wrap_step%0d got wa=%0d va=%0d mem=%0d want addr=%0d mem=%0d",
                             k, wr_addr[k], vf_addr[k], mem[exp_a[k]], exp_a[k], k + 1);
                end
            end
        end
    endtask

    task automatic test_stall();
        beats = '{4'h9, 4'h6, 4'hC}; gaps = '{0, 2, 0};
        run_burst(40, 3);
        gaps.delete();
        checks++;
        if (done_cyc !== 9 || err_seen !== 1'b0) begin
            errors++; $display("FAIL stall_done got cyc=%0d err=%b want cyc=9 err=0", done_cyc, err_seen);
        end
        checks++;
        if (wr_addr.size() !== 3) begin
            errors++; $display("FAIL stall_we_cycles got %0d want 3", wr_addr.size());
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem[40 + k] !== beats[k] || (k < wr_addr.size() && wr_addr[k] !== 40 + k)) begin
                errors++; $display("FAIL stall_mem[%0d] got %0d want %0d", 40 + k, mem[40 + k], beats[k]);
            end
        end
    endtask

    task automatic test_illegal();
        int bad[2] = '{0, 65};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start = 1; base_addr = 6'd5; len = bad[i][AW:0]; in_valid = 1; in_data = 4'hA;
            @(posedge clk); #1; start = 0;
            @(negedge clk);
            checks++;
            if ({done, err, mem_we, busy} !== 4'b1100) begin
                errors++;
                $display("FAIL illegal_len%0d got done=%b err=%b we=%b busy=%b want 1 1 0 0",
                         bad[i], done, err, mem_we, busy);
            end
            @(negedge clk);
            checks++;
            if ({done, err, mem_we} !== 3'b010) begin
                errors++; $display("FAIL illegal_hold%0d got done=%b err=%b we=%b want 0 1 0", bad[i], done, err, mem_we);
            end
            in_valid = 0;
        end
        beats.delete();
        for (int k = 0; k < 6; k++) beats.push_back(DW'($urandom));
        poke_start = 1;
        run_burst(10, 6);
        poke_start = 0;
        checks++;
        if (done_cyc !== 13 || err_seen !== 1'b0 || wr_addr.size() !== 6) begin
            errors++;
            $display("FAIL ignored_start got cyc=%0d err=%b writes=%0d want 13 0 6", done_cyc, err_seen, wr_addr.size());
        end
        for (int k = 0; k < wr_addr.size(); k++) begin
            checks++;
            if (wr_addr[k] !== 10 + k || wr_data[k] !== int'(beats[k])) begin
                errors++; $display("FAIL ignored_start_w%0d got addr=%0d want %0d", k, wr_addr[k], 10 + k);
            end
        end
    endtask

    task automatic test_mismatch();
        beats = '{4'h7}; gaps.delete();
        flip = 1;
        run_burst(33, 1);
        flip = 0;
        checks++;
        if (done_cyc !== 3 || err_seen !== 1'b1) begin
            errors++; $display("FAIL mismatch got cyc=%0d err=%b want cyc=3 err=1", done_cyc, err_seen);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1; base_addr = 6'd20; len = 7'd8; in_valid = 0;
        @(posedge clk); #1; start = 0; in_valid = 1; in_data = 4'h1;
        @(posedge clk); #1; in_data = 4'h2; rst = 1;
        @(posedge clk); #1; rst = 0; in_data = 4'h3;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, mem_we, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b busy=%b we=%b done=%b want 0000", in_ready, busy, mem_we, done);
        end
        in_valid = 0;
        beats.delete();
        for (int k = 0; k < 5; k++) beats.push_back(DW'($urandom));
        run_burst(30, 5);
        checks++;
        if (done_cyc !== 11 || err_seen !== 1'b0) begin
            errors++; $display("FAIL reset_mid_fresh got cyc=%0d err=%b want cyc=11 err=0", done_cyc, err_seen);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem[30 + k] !== beats[k]) begin
                errors++; $display("FAIL reset_mid_mem[%0d] got %0d want %0d", 30 + k, mem[30 + k], beats[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int b, l, exp_done, nbad;
            b = $urandom_range(0, DEPTH - 1);
            l = (t == 0) ? DEPTH : $urandom_range(1, DEPTH);
            beats.delete(); gaps.delete();
            exp_done = 2 * l + 1;
            for (int k = 0; k < l; k++) begin
                int g;
                beats.push_back(DW'($urandom));
                g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                gaps.push_back(g);
                exp_done += g;
            end
            run_burst(b, l);
            checks++;
            if (done_cyc !== exp_done || err_seen !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_done got cyc=%0d err=%b want cyc=%0d err=0", t, done_cyc, err_seen, exp_done);
            end
            nbad = 0;
            if (wr_addr.size() != l || vf_addr.size() != l) nbad++;
            for (int k = 0; k < l && nbad == 0; k++) begin
                if (wr_addr[k] != (b + k) % DEPTH || vf_addr[k] != (b + k) % DEPTH) nbad++;
                if (wr_data[k] != int'(beats[k]) || mem[(b + k) % DEPTH] !== beats[k]) nbad++;
            end
            checks++;
            if (nbad !== 0) begin
                errors++;
                $display("FAIL rand%0d_contents base=%0d len=%0d got writes=%0d verifies=%0d want %0d each, all matching",
                         t, b, l, wr_addr.size(), vf_addr.size(), l);
            end
        end
        gaps.delete();
    endtask

    initial begin
        rst = 1; start = 0; base_addr = '0; len = '0; in_valid = 0; in_data = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_illegal();
        test_mismatch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
